// File: rtl/spi_fpu_frontend.sv
// SPI mode-0 slave front-end for the SPI float unit: deserialises opcode + two
// operands, hands them to the FPU core over valid/ready, and streams status/result back on MISO.
module spi_fpu_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int OP_W        = 8,
   parameter int DATA_W      = 32,
   parameter int FLAG_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [OP_W-1:0]   op_code,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   input  logic [FLAG_W-1:0] res_flags,
   output logic              busy
);

   // state  | meaning
   // IDLE   | waiting for chip-select fall; loads the MISO status word on it
   // RECV   | shifting in the command frame, shifting out status/result
   // ISSUE  | command presented to the core until op_ready
   // DRAIN  | rest of the current CS window is ignored until CS rises
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_ISSUE, S_DRAIN} state_t;

   localparam int FRAME_W = OP_W + 2 * DATA_W;
   localparam int TX_W    = 3 + FLAG_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic [SYNC_STAGES:0]   r_sync_vld;
   logic                   r_sclk_d, r_cs_d;

   logic [FRAME_W-1:0] r_rx;
   logic [CNT_W-1:0]   r_cnt;
   logic [TX_W-1:0]    r_tx;
   logic [DATA_W-1:0]  r_hold_data;
   logic [FLAG_W-1:0]  r_hold_flags;
   logic               r_rdy, r_ovr, r_short;
   logic [OP_W-1:0]    r_op_code;
   logic [DATA_W-1:0]  r_op_a, r_op_b;

   logic w_sclk, w_cs, w_mosi, w_sync_ok;
   logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
   logic w_load, w_latch, w_ovr_set, w_short_set;

   // Edge detectors stay quiet until the chain and the delay flop hold real
   // pin samples, so a CS already low at reset release never opens a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
         r_sync_vld  <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs;
         r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sync_ok   = r_sync_vld[SYNC_STAGES];
   assign w_sclk_rise = w_sync_ok & w_sclk & ~r_sclk_d;
   assign w_sclk_fall = w_sync_ok & ~w_sclk & r_sclk_d;
   assign w_cs_fall   = w_sync_ok & ~w_cs & r_cs_d;
   assign w_cs_rise   = w_sync_ok & w_cs & ~r_cs_d;

   assign w_load      = (r_state == S_IDLE) && w_cs_fall;
   assign w_latch     = (r_state == S_RECV) && (r_cnt == CNT_FULL);
   assign w_ovr_set   = (r_state == S_ISSUE) && w_cs_fall;
   assign w_short_set = (r_state == S_RECV) && w_cs_rise && (r_cnt != CNT_FULL);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_cs_fall) w_state_nxt = S_RECV;
         S_RECV: begin
            if (r_cnt == CNT_FULL) w_state_nxt = S_ISSUE;
            else if (w_cs_rise)    w_state_nxt = S_IDLE;
         end
         S_ISSUE: if (op_ready) w_state_nxt = w_cs ? S_IDLE : S_DRAIN;
         S_DRAIN: if (w_cs_rise) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx         <= '0;
         r_cnt        <= '0;
         r_tx         <= '0;
         r_hold_data  <= '0;
         r_hold_flags <= '0;
         r_rdy        <= 1'b0;
         r_ovr        <= 1'b0;
         r_short      <= 1'b0;
         r_op_code    <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
      end else begin
         if (w_load) begin
            r_cnt <= '0;
            r_tx  <= {r_rdy, r_ovr, r_short, r_hold_flags, r_hold_data};
         end else if (r_state == S_RECV) begin
            if (w_sclk_rise && (r_cnt != CNT_FULL)) begin
               r_rx  <= {r_rx[FRAME_W-2:0], w_mosi};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_sclk_fall) r_tx <= {r_tx[TX_W-2:0], 1'b0};
         end

         if (w_latch) begin
            r_op_code <= r_rx[FRAME_W-1 -: OP_W];
            r_op_a    <= r_rx[2*DATA_W-1 -: DATA_W];
            r_op_b    <= r_rx[DATA_W-1:0];
         end

         // Sets take priority over the clear that accompanies a TX load.
         if (res_valid) begin
            r_hold_data  <= res_data;
            r_hold_flags <= res_flags;
         end
         if (res_valid)   r_rdy   <= 1'b1;
         else if (w_load) r_rdy   <= 1'b0;
         if (w_ovr_set)   r_ovr   <= 1'b1;
         else if (w_load) r_ovr   <= 1'b0;
         if (w_short_set) r_short <= 1'b1;
         else if (w_load) r_short <= 1'b0;
      end
   end

   assign op_valid    = (r_state == S_ISSUE);
   assign busy        = (r_state == S_ISSUE);
   assign op_code     = r_op_code;
   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign spi_miso    = ~w_cs & r_tx[TX_W-1];
   assign spi_miso_oe = ~w_cs;

endmodule

// File: tb/tb_spi_fpu_frontend.sv
// Directed-plus-random bench for spi_fpu_frontend: an SPI master drives frames,
// a status model predicts every MISO readout and every issued command.
module tb_spi_fpu_frontend;
   localparam int SYNC = 2;
   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, op_valid, busy;
   logic        op_ready = 1'b1;
   logic [7:0]  op_code;
   logic [31:0] op_a, op_b;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = '0;
   logic [4:0]  res_flags = '0;

   spi_fpu_frontend #(.SYNC_STAGES(SYNC), .OP_W(8), .DATA_W(32), .FLAG_W(5)) dut (
      .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_a(op_a), .op_b(op_b), .res_valid(res_valid),
      .res_data(res_data), .res_flags(res_flags), .busy(busy));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int valid_cyc = 0, busy_cyc = 0;
   logic [71:0] acc_q[$];

   // Status model: what the next CS window should read out.
   logic        m_rdy = 1'b0, m_ovr = 1'b0, m_short = 1'b0;
   logic [4:0]  m_flags = '0;
   logic [31:0] m_res = '0;

   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (op_valid) begin
            valid_cyc++;
            if (op_ready) acc_q.push_back({op_code, op_a, op_b});
         end
         if (busy) busy_cyc++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic take_status(output logic [39:0] exp);
      exp = {m_rdy, m_ovr, m_short, m_flags, m_res};
      m_rdy = 1'b0; m_ovr = 1'b0; m_short = 1'b0;
   endtask

   task automatic post_result(input logic [31:0] d, input logic [4:0] f);
      res_data = d; res_flags = f; res_valid = 1'b1;
      @(negedge clk);
      res_valid = 1'b0;
      m_rdy = 1'b1; m_res = d; m_flags = f;
   endtask

   task automatic spi_bits(input logic [71:0] d, input int n, output logic [39:0] rd);
      rd = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = d[71-i];
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b1;
         if (i < 40) rd = {rd[38:0], spi_miso};
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b0;
      end
      spi_mosi = 1'b0;
   endtask

   task automatic do_frame(input string tag, input logic [71:0] f, input int n);
      logic [39:0] rd, exp;
      int n0, v0;
      n0 = acc_q.size(); v0 = valid_cyc;
      take_status(exp);
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(f, n, rd);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check({tag, "_readout"}, 72'(rd), 72'(exp));
      if (n == 72) begin
         check({tag, "_issued"}, 72'(acc_q.size()), 72'(n0 + 1));
         if (acc_q.size() > 0) check({tag, "_op"}, acc_q[$], f);
      end else begin
         check({tag, "_no_issue"}, 72'(valid_cyc), 72'(v0));
         m_short = 1'b1;
      end
   endtask

   initial begin
      logic [39:0] rd, exp;
      logic [71:0] f;
      logic        stable, seen;
      int          n0, v0, b0;

      repeat (4) @(negedge clk);
      check("rst_op_valid", 72'(op_valid), 72'(0));
      check("rst_busy", 72'(busy), 72'(0));
      check("rst_miso", 72'(spi_miso), 72'(0));
      check("rst_miso_oe", 72'(spi_miso_oe), 72'(0));
      check("rst_ops", {op_code, op_a, op_b}, 72'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Basic issue with op_ready held high.
      v0 = valid_cyc; b0 = busy_cyc;
      do_frame("f1", {8'h01, 32'h3F80_0000, 32'h4000_0000}, 72);
      check("f1_valid_cycles", 72'(valid_cyc - v0), 72'(1));
      check("f1_busy_cycles", 72'(busy_cyc - b0), 72'(1));
      check("idle_miso_oe", 72'(spi_miso_oe), 72'(0));

      post_result(32'h4040_0000, 5'h00);
      do_frame("f2", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);
      do_frame("f3", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);

      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 3) != 0) post_result(32'($urandom), 5'($urandom));
         do_frame("rnd", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);
      end

      // Stalled core plus a frame that overlaps the stall.
      op_ready = 1'b0;
      f = {8'(32'($urandom)), 32'($urandom), 32'($urandom)};
      n0 = acc_q.size();
      take_status(exp);
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(f, 72, rd);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      check("stall_readout", 72'(rd), 72'(exp));
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (op_valid === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      check("stall_valid_seen", 72'(seen), 72'(1));
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 8) spi_cs_n = 1'b0;
         if (!(op_valid === 1'b1 && busy === 1'b1 && {op_code, op_a, op_b} === f)) stable = 1'b0;
      end
      check("stall_stable", 72'(stable), 72'(1));
      op_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("stall_released", 72'(op_valid), 72'(0));
      check("stall_issued", 72'(acc_q.size()), 72'(n0 + 1));
      if (acc_q.size() > 0) check("stall_op", acc_q[$], f);
      spi_bits({8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72, rd);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check("ovr_frame_ignored", 72'(acc_q.size()), 72'(n0 + 1));
      m_ovr = 1'b1;
      do_frame("after_ovr", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);

      // Short frame.
      do_frame("short", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 40);
      do_frame("after_short", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);

      // Result arriving on the same clock as the TX load.
      f = {8'(32'($urandom)), 32'($urandom), 32'($urandom)};
      n0 = acc_q.size();
      take_status(exp);
      spi_cs_n = 1'b0;
      repeat (SYNC) @(negedge clk);
      post_result(32'($urandom), 5'($urandom));
      repeat (6) @(negedge clk);
      spi_bits(f, 72, rd);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check("coinc_readout_old", 72'(rd), 72'(exp));
      check("coinc_issued", 72'(acc_q.size()), 72'(n0 + 1));
      do_frame("coinc_next", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);

      // Reset in the middle of a frame.
      post_result(32'($urandom), 5'($urandom));
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits({8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 30, rd);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_op_valid", 72'(op_valid), 72'(0));
      check("mid_rst_busy", 72'(busy), 72'(0));
      check("mid_rst_miso", 72'(spi_miso), 72'(0));
      check("mid_rst_miso_oe", 72'(spi_miso_oe), 72'(0));
      check("mid_rst_ops", {op_code, op_a, op_b}, 72'(0));
      rst = 1'b0;
      v0 = valid_cyc;
      repeat (20) @(negedge clk);
      check("post_rst_no_issue", 72'(valid_cyc), 72'(v0));
      spi_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      m_rdy = 1'b0; m_ovr = 1'b0; m_short = 1'b0; m_flags = '0; m_res = '0;
      do_frame("post_rst", {8'(32'($urandom)), 32'($urandom), 32'($urandom)}, 72);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_fpu_frontend.md
Name: spi_fpu_frontend

Overview:
SPI mode-0 slave front-end of the SPI float unit: deserialises command frames (opcode + two binary32 operands) from the pad-level SPI pins and issues them to the FPU core over a valid/ready handshake. It also captures the core's result and shifts status plus result back out on MISO during the next frame. It sits between the top-level pin mapping and the FPU datapath, and everything runs in the single system clock domain.

Parameters:
SYNC_STAGES, 2, synchroniser depth on sclk/cs_n/mosi (min 2)
OP_W, 8, opcode width
DATA_W, 32, operand/result width
FLAG_W, 5, IEEE exception flags width (NV, DZ, OF, UF, NX)

Ports:
clk  in  1  system clock; must be >= 4x SCLK frequency
rst  in  1  synchronous, active-high reset
spi_sclk  in  1  SPI clock, asynchronous to clk
spi_cs_n  in  1  chip select, active low, asynchronous
spi_mosi  in  1  serial data in, MSB first
spi_miso  out  1  serial data out, MSB first
spi_miso_oe  out  1  output enable for MISO pad (1 while CS asserted)
op_valid  out  1  command available to FPU core
op_ready  in  1  core accepts command when op_valid and op_ready are both high
op_code  out  OP_W  opcode, stable while op_valid
op_a  out  DATA_W  operand A
op_b  out  DATA_W  operand B
res_valid  in  1  one-cycle pulse: result available
res_data  in  DATA_W  result value
res_flags  in  FLAG_W  exception flags for the result
busy  out  1  high from frame completion until handshake completes

Behaviour:
- Sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops. An extra sclk flop gives rise/fall detection. cs_fall/cs_rise are detected on the synced cs_n. All logic acts on synced signals (latency SYNC_STAGES+1 clk).
- Reset: op_valid=0, busy=0, spi_miso=0, spi_miso_oe=0, op_code/op_a/op_b=0, holding register and status bits=0, state=IDLE, bit counter=0.
- Frame in: 72 bits = opcode[7:0], A[31:0], B[31:0], MSB first. MOSI is sampled on synced SCLK rise into a 72-bit shift register. A 7-bit counter counts the samples.
- FSM states and transitions:
  - IDLE: on cs_fall go to RECV, clear counter, load TX register.
  - RECV: sample on each rise. When counter reaches 72, latch op_code/op_a/op_b, set op_valid=1 and busy=1 on the next clk, go to ISSUE. If cs_rise arrives with counter < 72, set sticky SHORT and go to IDLE; no issue.
  - ISSUE: hold op_valid and outputs stable until op_ready (same-cycle acceptance allowed). Then clear op_valid and busy. Next state is DRAIN if CS is still low, else IDLE.
  - DRAIN: ignore further SCLK edges; go to IDLE on cs_rise.
  - A cs_rise during ISSUE does not abort the handshake.
  - A cs_fall during ISSUE sets sticky OVR; that frame is ignored entirely until its cs_rise, then the FSM returns to IDLE via DRAIN.
- Result capture: res_valid latches res_data and res_flags into the holding register and sets RDY. A later res_valid overwrites the holding register.
- TX: on cs_fall (IDLE only), load 40-bit tx = {RDY, OVR, SHORT, flags[4:0], result[31:0]} and clear RDY/OVR/SHORT in the same cycle.
  - If res_valid coincides with the load, tx takes the old holding contents, the holding register updates, and RDY ends set.
  - OVR/SHORT set in the same cycle as the clear win (remain set).
- MISO: spi_miso = tx[39] from load. Shift left on synced SCLK fall. After 40 bits shift in 0s. spi_miso=0 when CS is high.
- spi_miso_oe = ~synced cs_n.
- Counter saturates at 72; extra bits in RECV do not occur because the FSM moves to ISSUE.
- Reset mid-frame discards everything and returns to IDLE; the next frame starts only on a fresh cs_fall.

Test Plan:
- Frame 0x01, A=0x3F800000, B=0x40000000, op_ready held 1 -> one-cycle op_valid with op_code=0x01, op_a=0x3F800000, op_b=0x40000000; busy pulses one clk.
- After res_valid with 0x40400000, flags 0x00, run the next frame -> MISO returns 0x80 then 0x40400000; a third frame returns 0x00 then 0x40400000.
- op_ready held 0 for 20 clk after frame end -> op_valid/op_a stable for 20 clk; acceptance on the 21st; a new frame started during the wait sets OVR, and the next readout status = 0x40.
- CS deasserted after 40 bits -> no op_valid; next readout status bit SHORT set (0x20).
- res_valid in the same clk as cs_fall load -> that frame reads the old result; the following frame reads the new result with RDY=1.
- rst asserted after 30 received bits -> outputs return to reset values; a following full frame issues correctly.
